// File: rtl/uart_line_rx_if.sv
// Line output channel of uart_line_rx: a completed text line offered with a valid/ready handshake.
interface uart_line_rx_if #(
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned LW        = $clog2(MAX_CHARS + 1)
);
    logic                   line_ready;
    logic                   line_valid;
    logic [8*MAX_CHARS-1:0] line;
    logic [LW-1:0]          line_len;
    logic                   line_ovf;

    modport master (input line_ready, output line_valid, line, line_len, line_ovf);
    modport slave  (output line_ready, input line_valid, line, line_len, line_ovf);
endinterface

// File: rtl/uart_line_rx.sv
// UART receiver (configurable bit period) feeding a double-buffered text line assembler.
// Optional macro UART_PARITY_EN adds an even-parity bit per frame and the parity_err output.
module uart_line_rx #(
    parameter int unsigned CLK_DIV   = 217,
    parameter int unsigned MAX_CHARS = 16,
    parameter logic [7:0]  TERM      = 8'h0A
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_line_rx_if.master lo,
`ifdef UART_PARITY_EN
    output logic           parity_err,
`endif
    output logic           frame_err,
    output logic           line_lost
);
    localparam int unsigned   LW   = $clog2(MAX_CHARS + 1);
    localparam int unsigned   CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [LW-1:0] MAXC = LW'(MAX_CHARS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    logic          rx_m, rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          byte_ok, ferr, tick;
`ifdef UART_PARITY_EN
    logic          par_bad_q, par_bad_d, perr;
`endif

    logic [8*MAX_CHARS-1:0] asm_q;
    logic [LW-1:0]          count_q;
    logic                   ovf_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
`ifdef UART_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
`ifdef UART_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? cnt_q : cnt_q - CW'(1);
        idx_d     = idx_q;
        sh_d      = sh_q;
        byte_ok   = 1'b0;
        ferr      = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d = par_bad_q;
        perr      = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                cnt_d   = HALF;
            end
            START: if (tick) begin
                if (!rx_s) begin
                    state_d = DATA;
                    cnt_d   = FULL;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (tick) begin
                sh_d  = {rx_s, sh_q[7:1]};
                cnt_d = FULL;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (tick) begin
                par_bad_d = (rx_s != ^sh_q);
                cnt_d     = FULL;
                state_d   = STOP;
            end
`endif
            STOP: if (tick) begin
                if (rx_s) begin
                    state_d = IDLE;
`ifdef UART_PARITY_EN
                    byte_ok = !par_bad_q;
                    perr    = par_bad_q;
`else
                    byte_ok = 1'b1;
`endif
                end else begin
                    // Bad stop bit wins over a parity mismatch and waits out the line break.
                    ferr    = 1'b1;
                    state_d = BREAK;
                end
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q         <= '0;
            count_q       <= '0;
            ovf_acc       <= 1'b0;
            lo.line_valid <= 1'b0;
            lo.line       <= '0;
            lo.line_len   <= '0;
            lo.line_ovf   <= 1'b0;
            frame_err     <= 1'b0;
            line_lost     <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err    <= 1'b0;
`endif
        end else begin
            frame_err <= ferr;
            line_lost <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= perr;
`endif
            if (lo.line_valid && lo.line_ready) lo.line_valid <= 1'b0;
            if (byte_ok && sh_q != 8'h0D) begin
                if (sh_q == TERM) begin
                    if (count_q != '0) begin
                        // A load in the transfer cycle overrides the drop above (back-to-back).
                        if (!lo.line_valid || lo.line_ready) begin
                            lo.line_valid <= 1'b1;
                            lo.line       <= asm_q;
                            lo.line_len   <= count_q;
                            lo.line_ovf   <= ovf_acc;
                        end else begin
                            line_lost <= 1'b1;
                        end
                        asm_q   <= '0;
                        count_q <= '0;
                        ovf_acc <= 1'b0;
                    end
                end else if (count_q < MAXC) begin
                    for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                        if (LW'(i) == count_q) asm_q[8*i +: 8] <= sh_q;
                    end
                    count_q <= count_q + LW'(1);
                end else begin
                    ovf_acc <= 1'b1;
                end
            end
        end
    end
endmodule
